player_input_ctrl: RTL and testbench
====================================

# player_input_ctrl

Decodes the hps_io PS/2 key stream and merges it with the joystick_0/joystick_1 words into the registered, conditioned player control signals consumed by Main's joystick ports. It sits between hps_io and Main in the emu top level and replaces the inline key-latch logic. It adds:
- coin pulse stretching, so short taps are not missed by the game CPU;
- opposing-direction (SOCD) cleaning;
- optional latched pause.

## Interface
Parameters:
- COIN_PULSE_LEN, 16'd32768: minimum coin output high time in clock cycles. Legal range is ≥ 1.
- SOCD_NEUTRAL, 1: when 1, up+down or left+right pressed together forces both of that pair low.
- PAUSE_TOGGLE, 1: when 1, a pause press toggles a latch. When 0, pause passes through as held.

Ports:
- clock  in  1  system clock (clk_sys).
- reset_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joystick_0  in  32  player 1 joystick word from hps_io.
- joystick_1  in  32  player 2 joystick word from hps_io.
- p1_dir, p2_dir  out  4  {up, down, left, right}.
- p1_buttons, p2_buttons  out  3  {button_3, button_2, button_1}.
- p1_start, p2_start, p1_coin, p2_coin, p1_pause, p2_pause  out  1 each.
- service  out  2  {service_2, service_1}.

## Operation
- Clock and reset are fixed: one clock `clock`; reset `reset_n` is asynchronous and active-low. Reset clears every output, key register, coin counter, pause latch and edge-history register to 0. It also clears `primed`.
- Event detect:
  - `tog_q` holds the last sampled ps2_key[10].
  - The first edge after reset loads `tog_q` and sets `primed`. No key is decoded on that edge.
  - After that, an event is ps2_key[10] != tog_q.
  - On an event, the key register selected by code is loaded with ps2_key[9].
  - Unknown codes update only `tog_q`.
- Key map:
  - Player 1: 75 up, 72 down, 6B left, 74 right, 14 b1, 11 b2, 29 b3, 16 start, 2E coin, 4D pause.
  - Player 2: 2D up, 2B down, 23 left, 34 right, 1C b1, 1B b2, 15 b3, 1E start, 36 coin.
  - Service: 46 service_1, 45 service_2.
- Merge: raw = key | joystick bit.
  - Joystick bits: [3] up, [2] down, [1] left, [0] right, [4..6] b1..b3, [7] start, [8] coin, [9] pause, [10] service.
  - p2 pause comes from joystick_1[9] only.
- SOCD: applied to raw before registering when SOCD_NEUTRAL = 1.
- Coin (per player):
  - On an edge where raw_coin=1 and raw_coin_d=0: cnt <= COIN_PULSE_LEN-1 and coin <= 1.
  - Otherwise: cnt decrements if nonzero, and coin <= raw_coin | (cnt != 0).
  - A rising edge during an active pulse reloads cnt.
  - cnt width is clog2(COIN_PULSE_LEN+1); it never wraps below 0.
- Pause (per player):
  - With PAUSE_TOGGLE=1, each raw rising edge inverts the latch, and pause = latch.
  - With PAUSE_TOGGLE=0, pause = raw.
- No state machine beyond the primed/unprimed bit; all logic is registered.

## Timing
- Joystick change presented before edge E: output valid after E (1-cycle latency).
- PS/2 event presented before edge E: key register updates at E and output at E+1 (2-cycle latency).
- Coin: a single-cycle raw pulse gives exactly COIN_PULSE_LEN cycles of coin high, starting at the same edge as the merged output would. A raw level held longer than COIN_PULSE_LEN keeps coin high for its full duration.
- Simultaneous key release and joystick press on the same bit: output stays 1 (OR merge).
- Reset asserted mid-pulse or with a latched pause: both clear immediately (asynchronous). The first event after deassertion is discarded by priming.
- Back-to-back events on consecutive cycles are each decoded; no event is lost at one event per cycle.

## Structure
- Package `input_pkg`:
  - scan-code localparams (KEY_UP, KEY_CTRL, …);
  - joystick bit indices (JOY_RIGHT=0 … JOY_SERVICE=10);
  - the port bit-order constants for dir and buttons.
- Sub-module `pulse_stretch`: parameter LEN, ports clock, reset_n, in, out. It holds the rising-edge detect and reload counter. It is instantiated twice, for p1/p2 coin. The pause latch stays inline.

## Test plan
- Reset with ps2_key[10]=1 held, release reset → no key decoded on the first edge; all outputs 0.
- Toggle ps2_key[10] with code 75, pressed=1 → p1_dir=4'b1000 two edges later. Then an event with 75 and pressed=0 → 4'b0000.
- joystick_0[3] and joystick_0[2] both high, SOCD_NEUTRAL=1 → p1_dir[3:2]=00. With SOCD_NEUTRAL=0 → 11.
- COIN_PULSE_LEN=4, single-cycle joystick_1[8] → p2_coin high exactly 4 cycles. A retrigger on the 3rd cycle → high 6 cycles total.
- PAUSE_TOGGLE=1: press/release key 4D twice → p1_pause goes 1 after the first press and 0 after the second. Reset while latched → 0.
- Unknown code 0x5A event → all outputs unchanged, and the next valid event still decodes.

Source files
------------

// File: rtl/input_pkg.sv
// Shared constants for player_input_ctrl: PS/2 scan codes, joystick word bit positions and
// output bit order, plus the scan-code lookup and opposing-direction cleanup helpers.
package input_pkg;

  // Player 1 scan codes
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_CTRL  = 8'h14;
  localparam logic [7:0] KEY_ALT   = 8'h11;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_P     = 8'h4D;
  // Player 2 scan codes
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_G     = 8'h34;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_Q     = 8'h15;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_6     = 8'h36;
  // Service scan codes
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] KEY_0     = 8'h45;

  // Joystick word bits; key registers use the same positions
  localparam int unsigned JOY_RIGHT   = 0;
  localparam int unsigned JOY_LEFT    = 1;
  localparam int unsigned JOY_DOWN    = 2;
  localparam int unsigned JOY_UP      = 3;
  localparam int unsigned JOY_B1      = 4;
  localparam int unsigned JOY_B2      = 5;
  localparam int unsigned JOY_B3      = 6;
  localparam int unsigned JOY_START   = 7;
  localparam int unsigned JOY_COIN    = 8;
  localparam int unsigned JOY_PAUSE   = 9;
  localparam int unsigned JOY_SERVICE = 10;

  localparam int unsigned NUM_P1_KEYS = 10;
  localparam int unsigned NUM_P2_KEYS = 9;

  // Output port bit order
  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned BTN_1     = 0;
  localparam int unsigned BTN_2     = 1;
  localparam int unsigned BTN_3     = 2;

  typedef enum logic [1:0] {GrpNone, GrpP1, GrpP2, GrpSvc} key_grp_e;

  typedef struct packed {
    key_grp_e   grp;
    logic [3:0] idx;
  } key_sel_t;

  function automatic key_sel_t key_lookup(input logic [7:0] code);
    key_sel_t s;
    s = '{GrpNone, 4'd0};
    case (code)
      KEY_RIGHT: s = '{GrpP1, 4'(JOY_RIGHT)};
      KEY_LEFT:  s = '{GrpP1, 4'(JOY_LEFT)};
      KEY_DOWN:  s = '{GrpP1, 4'(JOY_DOWN)};
      KEY_UP:    s = '{GrpP1, 4'(JOY_UP)};
      KEY_CTRL:  s = '{GrpP1, 4'(JOY_B1)};
      KEY_ALT:   s = '{GrpP1, 4'(JOY_B2)};
      KEY_SPACE: s = '{GrpP1, 4'(JOY_B3)};
      KEY_1:     s = '{GrpP1, 4'(JOY_START)};
      KEY_5:     s = '{GrpP1, 4'(JOY_COIN)};
      KEY_P:     s = '{GrpP1, 4'(JOY_PAUSE)};
      KEY_G:     s = '{GrpP2, 4'(JOY_RIGHT)};
      KEY_D:     s = '{GrpP2, 4'(JOY_LEFT)};
      KEY_F:     s = '{GrpP2, 4'(JOY_DOWN)};
      KEY_R:     s = '{GrpP2, 4'(JOY_UP)};
      KEY_A:     s = '{GrpP2, 4'(JOY_B1)};
      KEY_S:     s = '{GrpP2, 4'(JOY_B2)};
      KEY_Q:     s = '{GrpP2, 4'(JOY_B3)};
      KEY_2:     s = '{GrpP2, 4'(JOY_START)};
      KEY_6:     s = '{GrpP2, 4'(JOY_COIN)};
      KEY_9:     s = '{GrpSvc, 4'd0};
      KEY_0:     s = '{GrpSvc, 4'd1};
      default:   s = '{GrpNone, 4'd0};
    endcase
    return s;
  endfunction

  // Opposing directions held together cancel to neutral
  function automatic logic [3:0] socd_clean(input logic [3:0] dir);
    logic [3:0] d;
    d = dir;
    if (dir[DIR_UP] && dir[DIR_DOWN]) begin
      d[DIR_UP]   = 1'b0;
      d[DIR_DOWN] = 1'b0;
    end
    if (dir[DIR_LEFT] && dir[DIR_RIGHT]) begin
      d[DIR_LEFT]  = 1'b0;
      d[DIR_RIGHT] = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Rising-edge triggered pulse stretcher: output stays high for at least LEN cycles after each
// rising edge of the input, and for as long as the input is held.
module pulse_stretch #(
  parameter int unsigned LEN = 32768
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic out
);

  localparam int unsigned CntW = $clog2(LEN + 1);

  logic [CntW-1:0] cnt_q;
  logic            in_q;
  logic            out_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      in_q  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      in_q <= in;
      if (in && !in_q) begin
        // The edge cycle itself is the first of the LEN high cycles
        cnt_q <= CntW'(LEN - 1);
        out_q <= 1'b1;
      end else begin
        if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
        out_q <= in | (cnt_q != '0);
      end
    end
  end

  assign out = out_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Decodes the hps_io PS/2 key stream, merges it with both joystick words and registers the
// conditioned player controls (SOCD cleanup, stretched coins, optional latched pause).
module player_input_ctrl
  import input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_LEN = 32768,
  parameter bit          SOCD_NEUTRAL   = 1'b1,
  parameter bit          PAUSE_TOGGLE   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  output logic [3:0]  p1_dir,
  output logic [3:0]  p2_dir,
  output logic [2:0]  p1_buttons,
  output logic [2:0]  p2_buttons,
  output logic        p1_start,
  output logic        p2_start,
  output logic        p1_coin,
  output logic        p2_coin,
  output logic        p1_pause,
  output logic        p2_pause,
  output logic [1:0]  service
);

  logic                   tog_q;
  logic                   primed_q;
  logic [NUM_P1_KEYS-1:0] p1_key_q;
  logic [NUM_P2_KEYS-1:0] p2_key_q;
  logic [1:0]             svc_key_q;
  key_sel_t               sel;
  logic                   key_event;

  assign sel       = key_lookup(ps2_key[7:0]);
  assign key_event = primed_q && (ps2_key[10] != tog_q);

  // The first edge after reset only learns the toggle phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tog_q     <= 1'b0;
      primed_q  <= 1'b0;
      p1_key_q  <= '0;
      p2_key_q  <= '0;
      svc_key_q <= '0;
    end else begin
      tog_q    <= ps2_key[10];
      primed_q <= 1'b1;
      if (key_event) begin
        case (sel.grp)
          GrpP1:   p1_key_q[sel.idx]     <= ps2_key[9];
          GrpP2:   p2_key_q[sel.idx]     <= ps2_key[9];
          GrpSvc:  svc_key_q[sel.idx[0]] <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  logic [9:0] raw1, raw2;
  logic [1:0] raw_svc, raw_pause;
  logic [3:0] dir1, dir2;

  assign raw1      = p1_key_q | joystick_0[9:0];
  assign raw2      = {joystick_1[JOY_PAUSE], p2_key_q | joystick_1[8:0]};
  assign raw_svc   = svc_key_q | {joystick_1[JOY_SERVICE], joystick_0[JOY_SERVICE]};
  assign raw_pause = {raw2[JOY_PAUSE], raw1[JOY_PAUSE]};

  always_comb begin
    dir1 = {raw1[JOY_UP], raw1[JOY_DOWN], raw1[JOY_LEFT], raw1[JOY_RIGHT]};
    dir2 = {raw2[JOY_UP], raw2[JOY_DOWN], raw2[JOY_LEFT], raw2[JOY_RIGHT]};
    if (SOCD_NEUTRAL) begin
      dir1 = socd_clean(dir1);
      dir2 = socd_clean(dir2);
    end
  end

  logic [3:0] p1_dir_q, p2_dir_q;
  logic [2:0] p1_btn_q, p2_btn_q;
  logic       p1_start_q, p2_start_q;
  logic [1:0] svc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_dir_q   <= '0;
      p2_dir_q   <= '0;
      p1_btn_q   <= '0;
      p2_btn_q   <= '0;
      p1_start_q <= 1'b0;
      p2_start_q <= 1'b0;
      svc_q      <= '0;
    end else begin
      p1_dir_q   <= dir1;
      p2_dir_q   <= dir2;
      p1_btn_q   <= {raw1[JOY_B3], raw1[JOY_B2], raw1[JOY_B1]};
      p2_btn_q   <= {raw2[JOY_B3], raw2[JOY_B2], raw2[JOY_B1]};
      p1_start_q <= raw1[JOY_START];
      p2_start_q <= raw2[JOY_START];
      svc_q      <= raw_svc;
    end
  end

  pulse_stretch #(.LEN(COIN_PULSE_LEN)) u_p1_coin (
    .clock  (clock),
    .reset_n(reset_n),
    .in     (raw1[JOY_COIN]),
    .out    (p1_coin)
  );

  pulse_stretch #(.LEN(COIN_PULSE_LEN)) u_p2_coin (
    .clock  (clock),
    .reset_n(reset_n),
    .in     (raw2[JOY_COIN]),
    .out    (p2_coin)
  );

  logic [1:0] pause_out;

  if (PAUSE_TOGGLE) begin : g_pause_toggle
    logic [1:0] pause_raw_q, pause_latch_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pause_raw_q   <= '0;
        pause_latch_q <= '0;
      end else begin
        pause_raw_q   <= raw_pause;
        pause_latch_q <= pause_latch_q ^ (raw_pause & ~pause_raw_q);
      end
    end
    assign pause_out = pause_latch_q;
  end else begin : g_pause_hold
    logic [1:0] pause_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pause_q <= '0;
      else          pause_q <= raw_pause;
    end
    assign pause_out = pause_q;
  end

  assign p1_dir     = p1_dir_q;
  assign p2_dir     = p2_dir_q;
  assign p1_buttons = p1_btn_q;
  assign p2_buttons = p2_btn_q;
  assign p1_start   = p1_start_q;
  assign p2_start   = p2_start_q;
  assign p1_pause   = pause_out[0];
  assign p2_pause   = pause_out[1];
  assign service    = svc_q;

  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: two configurations driven in parallel and compared against a
// key-table reference model, plus directed scenario checks.
module tb_player_input_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0, joystick_1;

  logic [3:0] a_p1_dir, a_p2_dir, b_p1_dir, b_p2_dir;
  logic [2:0] a_p1_btn, a_p2_btn, b_p1_btn, b_p2_btn;
  logic a_p1_start, a_p2_start, a_p1_coin, a_p2_coin, a_p1_pause, a_p2_pause;
  logic b_p1_start, b_p2_start, b_p1_coin, b_p2_coin, b_p1_pause, b_p2_pause;
  logic [1:0] a_svc, b_svc;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // A: SOCD on, 4-cycle coin, toggled pause.  B: SOCD off, 1-cycle coin, held pause.
  player_input_ctrl #(.COIN_PULSE_LEN(4), .SOCD_NEUTRAL(1'b1), .PAUSE_TOGGLE(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_dir(a_p1_dir), .p2_dir(a_p2_dir), .p1_buttons(a_p1_btn), .p2_buttons(a_p2_btn),
    .p1_start(a_p1_start), .p2_start(a_p2_start), .p1_coin(a_p1_coin), .p2_coin(a_p2_coin),
    .p1_pause(a_p1_pause), .p2_pause(a_p2_pause), .service(a_svc)
  );

  player_input_ctrl #(.COIN_PULSE_LEN(1), .SOCD_NEUTRAL(1'b0), .PAUSE_TOGGLE(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .p1_dir(b_p1_dir), .p2_dir(b_p2_dir), .p1_buttons(b_p1_btn), .p2_buttons(b_p2_btn),
    .p1_start(b_p1_start), .p2_start(b_p2_start), .p1_coin(b_p1_coin), .p2_coin(b_p2_coin),
    .p1_pause(b_p1_pause), .p2_pause(b_p2_pause), .service(b_svc)
  );

  wire [21:0] got_a = {a_p1_dir, a_p2_dir, a_p1_btn, a_p2_btn, a_p1_start, a_p2_start,
                       a_p1_coin, a_p2_coin, a_p1_pause, a_p2_pause, a_svc};
  wire [21:0] got_b = {b_p1_dir, b_p2_dir, b_p1_btn, b_p2_btn, b_p1_start, b_p2_start,
                       b_p1_coin, b_p2_coin, b_p1_pause, b_p2_pause, b_svc};

  // ---------------- reference model ----------------
  // Scan code of each joystick bit position, per player
  logic [7:0] p1_codes [10] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h16,
                                8'h2E, 8'h4D};
  logic [7:0] p2_codes [9]  = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1E,
                                8'h36};
  int  coin_len [2] = '{4, 1};

  bit        m_key [256];
  bit        m_primed, m_tog;
  bit [9:0]  r1, r2;
  bit [1:0]  sv;
  bit [3:0]  n1, n2;
  int        rem [2][2];
  bit        co [2][2];
  bit        prev_coin [2], prev_pause [2], par [2];
  bit        cin, pin;
  bit [21:0] exp_a, exp_b;

  function automatic bit [3:0] neutral(input bit [3:0] d);
    bit [3:0] o;
    o = d;
    if (d[3] && d[2]) o[3:2] = 2'b00;
    if (d[1] && d[0]) o[1:0] = 2'b00;
    return o;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_key[i]) m_key[i] = 1'b0;
      m_primed = 1'b0;
      m_tog    = 1'b0;
      for (int p = 0; p < 2; p++) begin
        prev_coin[p] = 0; prev_pause[p] = 0; par[p] = 0;
        for (int d = 0; d < 2; d++) begin rem[d][p] = 0; co[d][p] = 0; end
      end
      exp_a = '0;
      exp_b = '0;
    end else begin
      for (int i = 0; i < 10; i++) r1[i] = m_key[p1_codes[i]] | joystick_0[i];
      for (int i = 0; i < 9; i++)  r2[i] = m_key[p2_codes[i]] | joystick_1[i];
      r2[9] = joystick_1[9];
      sv = {m_key[8'h45] | joystick_1[10], m_key[8'h46] | joystick_0[10]};
      n1 = neutral(r1[3:0]);
      n2 = neutral(r2[3:0]);
      for (int p = 0; p < 2; p++) begin
        cin = (p == 0) ? r1[8] : r2[8];
        pin = (p == 0) ? r1[9] : r2[9];
        for (int d = 0; d < 2; d++) begin
          if (cin && !prev_coin[p]) rem[d][p] = coin_len[d];
          co[d][p] = cin || (rem[d][p] > 0);
          if (rem[d][p] > 0) rem[d][p]--;
        end
        if (pin && !prev_pause[p]) par[p] = ~par[p];
        prev_coin[p]  = cin;
        prev_pause[p] = pin;
      end
      exp_a = {n1, n2, r1[6:4], r2[6:4], r1[7], r2[7], co[0][0], co[0][1], par[0], par[1], sv};
      exp_b = {r1[3:0], r2[3:0], r1[6:4], r2[6:4], r1[7], r2[7], co[1][0], co[1][1],
               r1[9], r2[9], sv};
      if (!m_primed) begin
        m_primed = 1'b1;
        m_tog    = ps2_key[10];
      end else if (ps2_key[10] != m_tog) begin
        m_tog = ps2_key[10];
        m_key[ps2_key[7:0]] = ps2_key[9];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_key(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n    = 1'b0;
    joystick_0 = '0;
    joystick_1 = '0;
    ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
    repeat (3) @(negedge clock);
    checks++;
    if (got_a !== 22'd0) begin
      errors++; $display("FAIL reset_hold_a got=%h want=0", got_a);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b0000) begin
      errors++; $display("FAIL prime_discard got=%b want=0000", a_p1_dir);
    end
    checks++;
    if (got_a !== exp_a || got_b !== exp_b) begin
      errors++; $display("FAIL prime_model a=%h/%h b=%h/%h", got_a, exp_a, got_b, exp_b);
    end
  endtask

  task automatic test_key_event();
    send_key(8'h75, 1'b1);
    @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b0000) begin
      errors++; $display("FAIL key_latency1 got=%b want=0000", a_p1_dir);
    end
    @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b1000) begin
      errors++; $display("FAIL key_press got=%b want=1000", a_p1_dir);
    end
    send_key(8'h75, 1'b0);
    repeat (2) @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b0000 || got_a !== exp_a) begin
      errors++; $display("FAIL key_release got=%b want=0000", a_p1_dir);
    end
  endtask

  task automatic test_socd();
    joystick_0 = 32'h0000_000C;
    joystick_1 = 32'h0000_0003;
    @(negedge clock);
    checks++;
    if (a_p1_dir[3:2] !== 2'b00 || a_p2_dir !== 4'b0000) begin
      errors++; $display("FAIL socd_on got=%b/%b want=00/0000", a_p1_dir[3:2], a_p2_dir);
    end
    checks++;
    if (b_p1_dir[3:2] !== 2'b11 || b_p2_dir !== 4'b0011) begin
      errors++; $display("FAIL socd_off got=%b/%b want=11/0011", b_p1_dir[3:2], b_p2_dir);
    end
    joystick_0 = '0;
    joystick_1 = '0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_coin();
    int cnt_a, cnt_b;
    joystick_1 = 32'h100;
    @(negedge clock);
    joystick_1 = '0;
    cnt_a = int'(a_p2_coin);
    cnt_b = int'(b_p2_coin);
    repeat (12) begin
      @(negedge clock);
      cnt_a += int'(a_p2_coin);
      cnt_b += int'(b_p2_coin);
    end
    checks++;
    if (cnt_a != 4) begin errors++; $display("FAIL coin_len4 got=%0d want=4", cnt_a); end
    checks++;
    if (cnt_b != 1) begin errors++; $display("FAIL coin_len1 got=%0d want=1", cnt_b); end
    // Retrigger while the pulse is still active
    joystick_1 = 32'h100;
    @(negedge clock);
    joystick_1 = '0;
    cnt_a = int'(a_p2_coin);
    cnt_b = int'(b_p2_coin);
    @(negedge clock);
    cnt_a += int'(a_p2_coin);
    cnt_b += int'(b_p2_coin);
    joystick_1 = 32'h100;
    @(negedge clock);
    joystick_1 = '0;
    cnt_a += int'(a_p2_coin);
    cnt_b += int'(b_p2_coin);
    repeat (12) begin
      @(negedge clock);
      cnt_a += int'(a_p2_coin);
      cnt_b += int'(b_p2_coin);
    end
    checks++;
    if (cnt_a != 6) begin errors++; $display("FAIL coin_retrig got=%0d want=6", cnt_a); end
    checks++;
    if (cnt_b != 2) begin errors++; $display("FAIL coin_retrig_b got=%0d want=2", cnt_b); end
  endtask

  task automatic test_pause();
    logic exp_latch;
    exp_latch = 1'b0;
    for (int n = 0; n < 3; n++) begin
      send_key(8'h4D, 1'b1);
      repeat (2) @(negedge clock);
      exp_latch = ~exp_latch;
      checks++;
      if (a_p1_pause !== exp_latch || b_p1_pause !== 1'b1) begin
        errors++;
        $display("FAIL pause_press%0d got=%b/%b want=%b/1", n, a_p1_pause, b_p1_pause, exp_latch);
      end
      send_key(8'h4D, 1'b0);
      repeat (2) @(negedge clock);
      checks++;
      if (a_p1_pause !== exp_latch || b_p1_pause !== 1'b0) begin
        errors++;
        $display("FAIL pause_rel%0d got=%b/%b want=%b/0", n, a_p1_pause, b_p1_pause, exp_latch);
      end
    end
    // Latched now; start a coin pulse too, then reset mid-cycle
    joystick_0 = 32'h100;
    @(negedge clock);
    joystick_0 = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (a_p1_pause !== 1'b0 || a_p1_coin !== 1'b0 || got_a !== 22'd0) begin
      errors++; $display("FAIL async_reset got=%h want=0", got_a);
    end
    @(negedge clock);
    send_key(8'h75, 1'b1);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b0000 || got_a !== exp_a) begin
      errors++; $display("FAIL reprime got=%b want=0000", a_p1_dir);
    end
    send_key(8'h75, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_unknown();
    logic [21:0] snap;
    send_key(8'h6B, 1'b1);
    repeat (2) @(negedge clock);
    snap = got_a;
    send_key(8'h5A, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (got_a !== snap || snap !== exp_a) begin
      errors++; $display("FAIL unknown_code got=%h want=%h", got_a, snap);
    end
    send_key(8'h75, 1'b1);
    repeat (2) @(negedge clock);
    checks++;
    if (a_p1_dir !== 4'b1010) begin
      errors++; $display("FAIL after_unknown got=%b want=1010", a_p1_dir);
    end
    send_key(8'h75, 1'b0);
    @(negedge clock);
    send_key(8'h6B, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5] = '{8'h2D, 8'h1C, 8'h46, 8'h1E, 8'h45};
    for (int i = 0; i < 5; i++) begin
      send_key(seq[i], 1'b1);
      @(negedge clock);
      checks++;
      if (got_a !== exp_a) begin
        errors++; $display("FAIL b2b_step%0d got=%h want=%h", i, got_a, exp_a);
      end
    end
    @(negedge clock);
    checks++;
    if (a_p2_dir !== 4'b1000 || a_p2_btn !== 3'b001 || a_svc !== 2'b11 || a_p2_start !== 1'b1)
    begin
      errors++;
      $display("FAIL b2b_final got=%b %b %b %b want=1000 001 11 1", a_p2_dir, a_p2_btn, a_svc,
               a_p2_start);
    end
    // Keyboard release and joystick press on the same bit in the same cycle
    send_key(8'h2D, 1'b0);
    joystick_1 = 32'h8;
    repeat (2) @(negedge clock);
    checks++;
    if (a_p2_dir[3] !== 1'b1) begin
      errors++; $display("FAIL or_merge got=%b want=1", a_p2_dir[3]);
    end
    joystick_1 = '0;
    for (int i = 1; i < 5; i++) begin
      send_key(seq[i], 1'b0);
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (got_a !== 22'd0 || got_b !== 22'd0) begin
      errors++; $display("FAIL b2b_clear got=%h/%h want=0", got_a, got_b);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [23] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E,
                              8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E,
                              8'h36, 8'h46, 8'h45, 8'h5A, 8'h00};
    int bad;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      checks++;
      if (got_a !== exp_a || got_b !== exp_b) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_c%0d a=%h/%h b=%h/%h", c, got_a, exp_a, got_b, exp_b);
      end
      if ($urandom_range(3) == 0) joystick_0 = $urandom & 32'hFFFF_F7FF;
      if ($urandom_range(3) == 0) joystick_1 = $urandom;
      if ($urandom_range(2) == 0) begin
        ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), pool[$urandom_range(22)]};
      end else if ($urandom_range(7) == 0) begin
        // Non-event: toggle unchanged, code and pressed bits ignored
        ps2_key[9:0] = 10'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_event();
    test_socd();
    test_coin();
    test_pause();
    test_unknown();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
